// File: rtl/ysyx_24110015_arb_pkg.sv
// ysyx_24110015_arb_pkg: FSM states and response codes shared by the memory arbiter.
package ysyx_24110015_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/ysyx_24110015_rr_picker.sv
// ysyx_24110015_rr_picker: two-way one-hot winner select; on a tie the requester other than ptr wins.
module ysyx_24110015_rr_picker (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | ptr);
  assign gnt[1] = req[1] & (~req[0] | ~ptr);
endmodule

// File: rtl/ysyx_24110015_mem_arbiter.sv
// ysyx_24110015_mem_arbiter: IFU/LSU arbiter onto a single memory port, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the LSU always wins ties.
module ysyx_24110015_mem_arbiter
  import ysyx_24110015_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  output logic [1:0]  gnt,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] mem_araddr,
  output logic [31:0] mem_awaddr,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  input  logic [1:0]  mem_bresp,
  input  logic        mem_rvalid,
  input  logic        mem_bvalid
);
  state_t state;
  logic win, we_q, ptr;
  logic [7:0] cnt;
  logic [1:0] pick;
`ifdef ARB_ROUND_ROBIN_EN
  logic last;
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  assign ptr = last;
`else
  assign ptr = 1'b0;
`endif
  ysyx_24110015_rr_picker u_pick (.req(req), .ptr(ptr), .gnt(pick));
  // gnt is combinational so the winner sees acceptance in the cycle it requests
  assign gnt = (state == IDLE && !rst) ? pick : 2'b00;
  assign rsp_valid = (state == RESP) ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign mem_ren = state == ISSUE && !we_q;
  assign mem_wen = state == ISSUE && we_q;
  assign mem_awaddr = mem_araddr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      win <= 1'b0;
      we_q <= 1'b0;
      cnt <= '0;
      mem_araddr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rsp_rdata <= '0;
      rsp_resp <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: if (|pick) begin
          win <= pick[1];
          we_q <= |(pick & we & 2'b10);
          mem_araddr <= pick[1] ? addr[63:32] : addr[31:0];
          mem_wdata <= pick[1] ? wdata[63:32] : wdata[31:0];
          mem_wstrb <= pick[1] ? wstrb[7:4] : wstrb[3:0];
          state <= ISSUE;
        end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (we_q ? mem_bvalid : mem_rvalid) begin
          rsp_rdata <= we_q ? 32'h0 : mem_rdata;
          rsp_resp <= we_q ? mem_bresp : mem_rresp;
          state <= RESP;
        end else if (cnt == 8'(TIMEOUT_CYCLES)) begin
          rsp_rdata <= 32'h0;
          rsp_resp <= RESP_DECERR;
          state <= RESP;
        end else cnt <= cnt + 8'd1;
        RESP: if (rsp_ready[win]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
